// File: rtl/median16_filter.sv
// Windowed median/min/max filter for the ADC capture path.
// A window of N unsigned W-bit samples is latched on an accepted start
// strobe, sorted in place by an N-phase odd-even transposition network
// (one phase per clock), and the median, minimum and maximum are then
// registered alongside a one-cycle median_valid pulse.
module median16_filter #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] data_in,
  output logic           busy,
  output logic           median_valid,
  output logic [W-1:0]   median_out,
  output logic [W-1:0]   min_out,
  output logic [W-1:0]   max_out,
  output logic           overrun
);

  localparam int unsigned PW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [W-1:0]   arr        [N];
  logic [W-1:0]   arr_phase  [N];
  logic [PW-1:0]  phase;
  logic           last_phase;
  logic           accept;
  logic [W:0]     mid_sum;

  assign last_phase = (phase == PW'(N - 1));
  assign accept     = (state == IDLE) && start;
  assign busy       = (state != IDLE);

  // Middle pair sum carries one extra bit so an all-ones pair cannot wrap.
  assign mid_sum    = {1'b0, arr[N/2-1]} + {1'b0, arr[N/2]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> SORT on start, SORT for N phases, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = SORT;
      SORT:    if (last_phase) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // One transposition phase: even phases pair (0,1),(2,3)...; odd phases
  // pair (1,2),(3,4)... leaving both end slots untouched. Ties stay put.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      arr_phase[i] = arr[i];
    end
    if (!phase[0]) begin
      for (int unsigned i = 0; i + 1 < N; i += 2) begin
        if (arr[i] > arr[i+1]) begin
          arr_phase[i]   = arr[i+1];
          arr_phase[i+1] = arr[i];
        end
      end
    end else begin
      for (int unsigned i = 1; i + 2 < N; i += 2) begin
        if (arr[i] > arr[i+1]) begin
          arr_phase[i]   = arr[i+1];
          arr_phase[i+1] = arr[i];
        end
      end
    end
  end

  // Sample array and phase counter: load on accepted start, step while sorting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        arr[i] <= '0;
      end
      phase <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        arr[i] <= data_in[i*W +: W];
      end
      phase <= '0;
    end else if (state == SORT) begin
      for (int unsigned i = 0; i < N; i++) begin
        arr[i] <= arr_phase[i];
      end
      phase <= phase + 1'b1;
    end
  end

  // Result registers and status pulses; results hold between valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      median_valid <= 1'b0;
      overrun      <= 1'b0;
      median_out   <= '0;
      min_out      <= '0;
      max_out      <= '0;
    end else begin
      median_valid <= (state == DONE);
      overrun      <= start && (state != IDLE);
      if (state == DONE) begin
        median_out <= mid_sum[W:1];
        min_out    <= arr[0];
        max_out    <= arr[N-1];
      end
    end
  end

endmodule

// File: tb/tb_median16_filter.sv
// Directed bench for median16_filter: latency, busy window, sort results,
// all-ones median sum, overrun handling, async abort and output holding.
module tb_median16_filter;

  localparam int unsigned N = 16;
  localparam int unsigned W = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N*W-1:0] data_in;
  logic           busy;
  logic           median_valid;
  logic [W-1:0]   median_out;
  logic [W-1:0]   min_out;
  logic [W-1:0]   max_out;
  logic           overrun;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] slots [N];

  always #5 clk = ~clk;

  median16_filter #(.N(N), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data_in      (data_in),
    .busy         (busy),
    .median_valid (median_valid),
    .median_out   (median_out),
    .min_out      (min_out),
    .max_out      (max_out),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_slots();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = slots[i];
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge (k=0).
  task automatic launch();
    data_in = pack_slots();
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Bounded wait for median_valid, counting busy cycles on the way.
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (median_valid) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int med, input int mn, input int mx);
    check({tag, ".median"}, 32'(median_out), 32'(med));
    check({tag, ".min"},    32'(min_out),    32'(mn));
    check({tag, ".max"},    32'(max_out),    32'(mx));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bc;
    int vcount;
    logic [W-1:0] tmp;
    int j;

    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("reset.valid",   32'(median_valid), 0);
    check("reset.busy",    32'(busy), 0);
    check("reset.overrun", 32'(overrun), 0);
    check_result("reset", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ascending window; data_in is cleared right after start and must not matter.
    for (int i = 0; i < N; i++) slots[i] = W'(i);
    launch();
    data_in = '0;
    wait_valid(lat, bc);
    check("asc.latency", 32'(lat), 17);
    check("asc.busy_cycles", 32'(bc), 17);
    check("asc.busy_at_valid", 32'(busy), 0);
    check_result("asc", 7, 0, 15);
    @(negedge clk);
    check("asc.pulse_width", 32'(median_valid), 0);

    // Descending window, then all-equal window.
    for (int i = 0; i < N; i++) slots[i] = W'(15 - i);
    launch();
    wait_valid(lat, bc);
    check("desc.latency", 32'(lat), 17);
    check_result("desc", 7, 0, 15);
    @(negedge clk);
    for (int i = 0; i < N; i++) slots[i] = 12'hABC;
    launch();
    wait_valid(lat, bc);
    check("same.latency", 32'(lat), 17);
    check_result("same", 12'hABC, 12'hABC, 12'hABC);
    @(negedge clk);

    // Alternating 0xFFF / 0x000: needs the extra sum bit.
    for (int i = 0; i < N; i++) slots[i] = (i % 2 == 0) ? 12'hFFF : 12'h000;
    launch();
    wait_valid(lat, bc);
    check("alt.latency", 32'(lat), 17);
    check_result("alt", 12'h7FF, 12'h000, 12'hFFF);
    @(negedge clk);

    // Overrun: second start at edge T+5 is ignored.
    for (int i = 0; i < N; i++) slots[i] = W'(i * 3);
    launch();
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) slots[i] = 12'h111;
    data_in = pack_slots();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ovr.overrun_pulse", 32'(overrun), 1);
    check("ovr.busy", 32'(busy), 1);
    @(negedge clk);
    check("ovr.overrun_clear", 32'(overrun), 0);
    wait_valid(lat, bc);
    check("ovr.latency", 32'(lat), 11);
    check_result("ovr", 22, 0, 45);
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (median_valid) vcount++;
    end
    check("ovr.no_second_valid", 32'(vcount), 0);

    // Asynchronous abort mid-sort, then start on the first edge after release.
    for (int i = 0; i < N; i++) slots[i] = W'(i + 50);
    launch();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.busy_async", 32'(busy), 0);
    check_result("abort.async", 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("abort.valid", 32'(median_valid), 0);
    check("abort.busy", 32'(busy), 0);
    check_result("abort.held", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) slots[i] = W'(100 * (i + 1));
    launch();
    wait_valid(lat, bc);
    check("post_rst.latency", 32'(lat), 17);
    check_result("post_rst", 850, 100, 1600);
    @(negedge clk);

    // Duplicate values in shuffled slot order, windows spaced 4000 cycles apart.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < N; i++) slots[i] = (i < 8) ? W'(5) : W'(9);
      for (int i = N - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = slots[i];
        slots[i] = slots[j];
        slots[j] = tmp;
      end
      launch();
      repeat (8) @(negedge clk);
      if (w > 0) check_result($sformatf("dup%0d.hold_during_sort", w), 7, 5, 9);
      else       check_result("dup0.hold_during_sort", 850, 100, 1600);
      wait_valid(lat, bc);
      check($sformatf("dup%0d.latency", w), 32'(lat), 9);
      check_result($sformatf("dup%0d", w), 7, 5, 9);
      vcount = 0;
      for (int k = 0; k < 4000; k++) begin
        @(negedge clk);
        if (median_valid) vcount++;
        if (k % 1000 == 999) check_result($sformatf("dup%0d.hold", w), 7, 5, 9);
      end
      check($sformatf("dup%0d.gap_valids", w), 32'(vcount), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/median16_filter.md
Name: median16_filter

Overview:
- Sits directly downstream of the ADC sample-capture stage.
- Consumes the packed window of the 16 most recent 12-bit ADC samples and the one-cycle "window stored" strobe.
- Sorts the window with a sequential odd-even transposition network and outputs the median, minimum and maximum as registered values with a one-cycle valid pulse.
- Its output replaces the raw sample as the filtered value for the downstream display/transmit logic.

Parameters:
- N, 16, number of samples in the window; must be even and at least 4.
- W, 12, sample width in bits; samples are unsigned.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle strobe: the window on data_in is complete (driven by the capture stage's store-finish pulse).
- data_in  input  N*W  packed window; slot i = data_in[i*W +: W]. Slot order is irrelevant to the result.
- busy  output  1  high from the cycle after an accepted start until median_valid asserts.
- median_valid  output  1  one-cycle pulse; median_out/min_out/max_out are updated in that cycle.
- median_out  output  W  floor((s[N/2-1] + s[N/2]) / 2) of the sorted window.
- min_out  output  W  s[0], the smallest sample.
- max_out  output  W  s[N-1], the largest sample.
- overrun  output  1  one-cycle pulse when start arrives while the block is not IDLE.

Behaviour:
- Reset values: state IDLE; busy=0, median_valid=0, overrun=0, median_out=0, min_out=0, max_out=0; internal array and phase counter are cleared.
- States: IDLE -> SORT -> DONE -> IDLE.
- IDLE:
  - If start=1 at edge T, all N slots are copied from data_in into the internal array, phase counter is set to 0, and the state moves to SORT.
  - busy=1 from the cycle after T.
- SORT: performs one phase per clock, N phases total, at edges T+1 .. T+N.
  - Even phase (counter bit0=0): compare-exchange pairs (0,1),(2,3),...,(N-2,N-1).
  - Odd phase: compare-exchange pairs (1,2),(3,4),...,(N-3,N-2). Slots 0 and N-1 are untouched.
  - Compare-exchange is an unsigned comparison. Swap only if a[i] > a[i+1], giving ascending order. Equal values are never swapped.
  - After the phase with counter=N-1, the state moves to DONE.
- DONE: at edge T+N+1, register the outputs:
  - median_out = (a[N/2-1] + a[N/2]) >> 1. The sum is computed at W+1 bits, with no overflow and no rounding up.
  - min_out = a[0]; max_out = a[N-1].
  - median_valid=1 for exactly one cycle; busy=0; state returns to IDLE.
- Latency: median_valid is high in the cycle following edge T+N+1, i.e. 17 clocks after the start edge (T+17) for N=16.
- Output holding: median_out, min_out and max_out hold their value until the next median_valid.
- Start while busy:
  - A start seen while the state is SORT or DONE, including at the DONE->IDLE edge, is ignored. The array is not reloaded and the sort continues unaffected.
  - overrun pulses for one cycle.
- Start and reset: an asynchronous rst during SORT/DONE aborts immediately. No median_valid is produced for the aborted window, and all outputs return to their reset values. A start on the first edge after rst deassertion is accepted normally.
- data_in is sampled only at the accepted start edge. Changes afterwards have no effect on the running sort.
- Throughput: one window per N+2 cycles maximum. The upstream stage delivers a window far less often, so overrun indicates an integration fault.

Test Plan:
- Slot i = i (0..15), start pulse -> busy high for 17 cycles; median_valid pulses at T+17 with median_out=7, min_out=0, max_out=15.
- Slot i = 15-i (descending), then slots all 0xABC -> first result median 7/min 0/max 15; second result median 0xABC, min 0xABC, max 0xABC.
- Eight slots 0xFFF interleaved with eight slots 0x000 -> median_out=0x7FF (checks the 13-bit sum), min_out=0x000, max_out=0xFFF.
- Start at T, second start with a different window at T+5 -> overrun pulses at T+5; single median_valid at T+17 carrying the first window's result; no second valid.
- Start, then rst asserted at T+6 for 2 cycles -> all outputs 0, busy 0, no median_valid. A new start after release with slots {100,200,...,1600} -> median_out=850, min_out=100, max_out=1600.
- Duplicates {5 x8, 9 x8} in random slot order, followed by back-to-back windows at a 4000-cycle spacing -> each median_out=7; outputs hold stable between valid pulses.
